// File: rtl/proc_trace_pkg.sv
// Shared types for the processor commit-trace buffer: FSM states and the
// packed trace entry stored in the FIFO.
package proc_trace_pkg;

  localparam int TRACE_ENTRY_W = 96;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FROZEN  = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] data;
  } trace_entry_t;

endpackage

// File: rtl/proc_trace_fifo.sv
// Power-of-two FIFO holding trace entries; a push into a full FIFO is taken
// only when a pop frees the head slot in the same cycle.
module proc_trace_fifo
  import proc_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [TRACE_ENTRY_W-1:0] wdata,
  output logic [TRACE_ENTRY_W-1:0] rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [TRACE_ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic                     pop_eff;
  logic                     push_eff;

  // Count never exceeds DEPTH, so its MSB alone marks the full condition.
  assign full     = count[AW];
  assign empty    = (count == '0);
  assign pop_eff  = pop && !empty;
  assign push_eff = push && (!full || pop_eff);
  assign rdata    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + 1'b1;
      if (pop_eff)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_eff, pop_eff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; occupancy is tracked by count/pointers, so
  // stale contents are never visible and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/proc_trace_buf.sv
// Commit-trace capture buffer: arms on request, records one entry per valid
// trace cycle, freezes on an optional stop address and drains via handshake.
module proc_trace_buf
  import proc_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arm,
  input  logic                   stop_en,
  input  logic [31:0]            stop_addr,
  input  logic                   trace_val,
  input  logic [31:0]            trace_addr,
  input  logic [31:0]            trace_inst,
  input  logic [31:0]            trace_data,
  output logic                   deq_val,
  input  logic                   deq_rdy,
  output logic [31:0]            deq_addr,
  output logic [31:0]            deq_inst,
  output logic [31:0]            deq_data,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            drop_count,
  output logic [1:0]             state
);

  state_e       state_q;
  state_e       state_d;
  trace_entry_t wr_entry;
  trace_entry_t head;
  logic         push_req;
  logic         trigger;
  logic         full;
  logic         empty;
  logic         drop;

  assign push_req = (state_q == ST_CAPTURE) && trace_val;
  assign trigger  = push_req && stop_en && (trace_addr == stop_addr);
  assign wr_entry = '{addr: trace_addr, inst: trace_inst, data: trace_data};

  proc_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (deq_rdy),
    .wdata (wr_entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // A full FIFO always has deq_val set, so deq_rdy alone decides whether the
  // head slot is freed for the incoming entry.
  assign drop    = push_req && full && !deq_rdy;
  assign deq_val = !empty;
  assign {deq_addr, deq_inst, deq_data} = deq_val ? head : '0;
  assign state   = state_q;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (arm)     state_d = ST_CAPTURE;
      ST_CAPTURE: if (trigger) state_d = ST_FROZEN;
      ST_FROZEN:  if (arm)     state_d = ST_CAPTURE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its sources regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      drop_count <= '0;
    end else begin
      state_q <= state_d;
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_proc_trace_buf.sv
// Self-checking bench for proc_trace_buf: directed table, hand sequences for
// overflow/freeze/reset/saturation, and randomized traffic against a queue model.
module tb_proc_trace_buf;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          arm = 1'b0;
  logic          stop_en = 1'b0;
  logic [31:0]   stop_addr = '0;
  logic          trace_val = 1'b0;
  logic [31:0]   trace_addr = '0;
  logic [31:0]   trace_inst = '0;
  logic [31:0]   trace_data = '0;
  logic          deq_val;
  logic          deq_rdy = 1'b0;
  logic [31:0]   deq_addr;
  logic [31:0]   deq_inst;
  logic [31:0]   deq_data;
  logic [CW-1:0] count;
  logic [15:0]   drop_count;
  logic [1:0]    state;

  always #5 clk = ~clk;

  proc_trace_buf #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .stop_en    (stop_en),
    .stop_addr  (stop_addr),
    .trace_val  (trace_val),
    .trace_addr (trace_addr),
    .trace_inst (trace_inst),
    .trace_data (trace_data),
    .deq_val    (deq_val),
    .deq_rdy    (deq_rdy),
    .deq_addr   (deq_addr),
    .deq_inst   (deq_inst),
    .deq_data   (deq_data),
    .count      (count),
    .drop_count (drop_count),
    .state      (state)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: entries as {addr, inst, data} in an unbounded queue,
  // the mode as a small integer (0 idle, 1 capturing, 2 frozen).
  logic [95:0] m_q[$];
  int          m_mode = 0;
  int          m_drops = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return ~a;
  endfunction

  task automatic model_cycle(input bit r, input bit a, input bit se, input logic [31:0] sa,
                             input bit tv, input logic [95:0] e, input bit rdy);
    bit had_room;
    bit do_pop;
    if (r) begin
      m_q.delete();
      m_mode  = 0;
      m_drops = 0;
      return;
    end
    had_room = (m_q.size() < DEPTH);
    do_pop   = (m_q.size() != 0) && rdy;
    if (do_pop) void'(m_q.pop_front());
    if (m_mode == 1 && tv) begin
      if (had_room || do_pop) m_q.push_back(e);
      else if (m_drops < 65535) m_drops++;
    end
    case (m_mode)
      0: if (a) m_mode = 1;
      1: if (tv && se && e[95:64] == sa) m_mode = 2;
      2: if (a) m_mode = 1;
      default: m_mode = 0;
    endcase
  endtask

  task automatic compare_model();
    logic [95:0] h;
    h = (m_q.size() != 0) ? m_q[0] : 96'd0;
    check("state", 32'(state), 32'(m_mode));
    check("count", 32'(count), 32'(m_q.size()));
    check("drop_count", 32'(drop_count), 32'(m_drops));
    check("deq_val", 32'(deq_val), 32'(m_q.size() != 0));
    check("deq_addr", deq_addr, h[95:64]);
    check("deq_inst", deq_inst, h[63:32]);
    check("deq_data", deq_data, h[31:0]);
  endtask

  // One clock: drive inputs away from the edge, clock, advance model, compare.
  task automatic step_full(input bit r, input bit a, input bit se, input logic [31:0] sa,
                           input bit tv, input logic [31:0] ta, input logic [31:0] ti,
                           input logic [31:0] td, input bit rdy);
    rst = r; arm = a; stop_en = se; stop_addr = sa;
    trace_val = tv; trace_addr = ta; trace_inst = ti; trace_data = td; deq_rdy = rdy;
    @(posedge clk);
    model_cycle(r, a, se, sa, tv, {ta, ti, td}, rdy);
    #1;
    compare_model();
  endtask

  task automatic step(input bit r, input bit a, input bit tv, input logic [31:0] ta, input bit rdy);
    step_full(r, a, 1'b0, 32'd0, tv, ta, inst_of(ta), data_of(ta), rdy);
  endtask

  typedef struct {
    bit          rst;
    bit          arm;
    bit          tv;
    logic [31:0] addr;
    bit          rdy;
    int          exp_state;
    int          exp_count;
    logic [31:0] exp_head;
  } vec_t;

  vec_t vecs[9];
  logic [31:0] exp_addr[8];

  initial begin
    vecs[0] = '{1, 0, 0, 32'h000, 0, 0, 0, 32'h000};
    vecs[1] = '{0, 1, 0, 32'h000, 0, 1, 0, 32'h000};
    vecs[2] = '{0, 0, 1, 32'h200, 1, 1, 1, 32'h200};
    vecs[3] = '{0, 0, 1, 32'h204, 1, 1, 1, 32'h204};
    vecs[4] = '{0, 0, 1, 32'h208, 1, 1, 1, 32'h208};
    vecs[5] = '{0, 0, 0, 32'h000, 1, 1, 0, 32'h000};
    vecs[6] = '{0, 1, 1, 32'h300, 0, 1, 1, 32'h300};
    vecs[7] = '{1, 0, 1, 32'h304, 0, 0, 0, 32'h000};
    vecs[8] = '{0, 0, 1, 32'h308, 0, 0, 0, 32'h000};

    repeat (2) @(posedge clk);
    #1;

    // Basic capture/drain flow, arm ignored while capturing, reset, idle ignore.
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].rst, vecs[i].arm, vecs[i].tv, vecs[i].addr, vecs[i].rdy);
      check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_head", i), deq_addr, vecs[i].exp_head);
    end

    // Overflow: ten traces into eight slots, then drain in order.
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 32'h200 + 32'(4 * i), 0);
    check("ovf_count", 32'(count), 32'd8);
    check("ovf_drops", 32'(drop_count), 32'd2);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ovf_drain%0d", i), deq_addr, 32'h200 + 32'(4 * i));
      step(0, 0, 0, 0, 1);
    end
    check("ovf_empty", 32'(count), 32'd0);

    // Push into full FIFO with a simultaneous pop: accepted, lands last.
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 32'h400 + 32'(4 * i), 0);
    step(0, 0, 1, 32'h4FC, 1);
    check("full_pp_count", 32'(count), 32'd8);
    check("full_pp_drops", 32'(drop_count), 32'd0);
    for (int i = 0; i < 7; i++) exp_addr[i] = 32'h404 + 32'(4 * i);
    exp_addr[7] = 32'h4FC;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("full_pp_drain%0d", i), deq_addr, exp_addr[i]);
      step(0, 0, 0, 0, 1);
    end

    // Stop-on-address freeze, later traces ignored, re-arm resumes.
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a;
      a = 32'h200 + 32'(4 * i);
      step_full(0, 0, 1, 32'h20C, 1, a, inst_of(a), data_of(a), 0);
    end
    check("frz_state", 32'(state), 32'd2);
    check("frz_count", 32'(count), 32'd4);
    check("frz_head", deq_addr, 32'h200);
    step(0, 1, 0, 0, 0);
    check("rearm_state", 32'(state), 32'd1);
    step(0, 0, 1, 32'h500, 0);
    check("rearm_count", 32'(count), 32'd5);

    // Reset with five entries while capturing discards everything.
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("pre_rst_count", 32'(count), 32'd3);
    step(0, 0, 1, 32'h600, 0);
    step(0, 0, 1, 32'h604, 0);
    check("pre_rst_count5", 32'(count), 32'd5);
    step(1, 0, 1, 32'h608, 0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_deq_val", 32'(deq_val), 32'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h700, 1);
    check("rst_ignore", 32'(count), 32'd0);

    // Drop counter saturation.
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 32'h800 + 32'(4 * i), 0);
    for (int i = 0; i < 65535; i++) step(0, 0, 1, 32'h900, 0);
    check("sat_reach", 32'(drop_count), 32'hFFFF);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 32'h900, 0);
    check("sat_hold", 32'(drop_count), 32'hFFFF);

    // Randomized traffic against the model.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit          r, a, se, tv, rdy;
      logic [31:0] ta, sa;
      r   = ($urandom_range(0, 199) == 0);
      a   = ($urandom_range(0, 9) == 0);
      se  = ($urandom_range(0, 3) == 0);
      tv  = ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 1) == 1);
      ta  = 32'h1000 + 32'(4 * $urandom_range(0, 15));
      sa  = 32'h1000 + 32'(4 * $urandom_range(0, 15));
      step_full(r, a, se, sa, tv, ta, $urandom, $urandom, rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
